// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, tick-sampled debounce, press/auto-repeat
// pulses per button, and a 2-bit counter that runs while any button is held.

module button_lane #(
    parameter logic [9:0] REPEAT_DELAY = 10'd381,
    parameter logic [9:0] REPEAT_RATE  = 10'd76,
    parameter bit         REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic tick_dly,
    input  logic sync_bit,
    output logic pulse,
    output logic level
);
    logic [2:0] sh_q, sh_d;
    logic [9:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       pulse_q, pulse_d;
    logic       press, release_ev, rpt;
    logic [9:0] cnt_inc;

    assign cnt_inc = cnt_q + 10'd1;

    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rpt        = 1'b0;
        if (tick) sh_d = {sync_bit, sh_q[2:1]};
        press      = tick_dly & sh_q[2] & sh_q[1] & ~sh_q[0];
        release_ev = tick_dly & ~sh_q[2] & ~sh_q[1];
        if (press)           level_d = 1'b1;
        else if (release_ev) level_d = 1'b0;
        // Reloading to DELAY-RATE makes every later repeat land RATE ticks apart.
        if (!REPEAT_EN || press || !level_q) begin
            cnt_d = '0;
        end else if (tick_dly) begin
            if (cnt_inc == REPEAT_DELAY) begin
                rpt   = 1'b1;
                cnt_d = REPEAT_DELAY - REPEAT_RATE;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        pulse_d = press | rpt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;
endmodule

module button_conditioner #(
    parameter int unsigned TICK_DIV     = 17,
    parameter logic [9:0]  REPEAT_DELAY = 10'd381,
    parameter logic [9:0]  REPEAT_RATE  = 10'd76,
    parameter logic [4:0]  REPEAT_MASK  = 5'b11000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] pulse,
    output logic [4:0] level,
    output logic [1:0] random,
    output logic       tick
);
    localparam int NUM_BTN = 5;

    logic [NUM_BTN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TICK_DIV-1:0] tdiv_q, tdiv_d;
    logic                tick_dly_q, tick_dly_d;
    logic [1:0]          rand_q, rand_d;

    assign tick = &tdiv_q;

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        tdiv_d     = tdiv_q + 1'b1;
        tick_dly_d = tick;
        rand_d     = rand_q + {1'b0, |sync2_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tdiv_q     <= '0;
            tick_dly_q <= 1'b0;
            rand_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tdiv_q     <= tdiv_d;
            tick_dly_q <= tick_dly_d;
            rand_q     <= rand_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        button_lane #(
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_EN   (REPEAT_MASK[i])
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .tick_dly(tick_dly_q),
            .sync_bit(sync2_q[i]),
            .pulse   (pulse[i]),
            .level   (level[i])
        );
    end

    assign random = rand_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a tick-level reference model predicts every output each
// cycle; a negedge monitor pops and compares.

module tb_button_conditioner;
    localparam int P = 16;
    localparam int D = 4;
    localparam int R = 2;
    localparam logic [4:0] MASK = 5'b11000;

    typedef struct packed {
        logic [4:0] pulse;
        logic [4:0] level;
        logic [1:0] rnd;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn_raw = 5'b11111;
    logic [4:0] pulse, level;
    logic [1:0] random;
    logic       tick;

    button_conditioner #(
        .TICK_DIV(4), .REPEAT_DELAY(10'd4), .REPEAT_RATE(10'd2), .REPEAT_MASK(5'b11000)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .pulse(pulse), .level(level), .random(random), .tick(tick)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    logic [4:0] raw_h[$];
    logic [4:0] samp[$];
    logic [4:0] m_level = '0;
    int         m_n[5];
    int         m_rnd = 0;
    int         c = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cnt_l = 0;
    int         cnt_m = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, expv);
        end
    endtask

    // Reference model: samples are taken every P cycles from the pin delayed
    // two cycles; decisions land two cycles after each sample tick.
    task automatic step(input logic r_n, input logic [4:0] b);
        exp_t       e;
        logic [4:0] sy, sk, sk1, sk2;
        int         k;
        @(posedge clk);
        #1;
        rst     = r_n;
        btn_raw = b;
        e       = '0;
        if (!r_n) begin
            c = 0;
            raw_h.delete();
            samp.delete();
            m_level = '0;
            m_rnd   = 0;
            for (int i = 0; i < 5; i++) m_n[i] = 0;
        end else begin
            c++;
            raw_h.push_back(b);
            sy    = (c >= 3) ? raw_h[c-3] : 5'd0;
            e.rnd = 2'(m_rnd);
            if (sy != 5'd0) m_rnd = (m_rnd + 1) % 4;
            e.tick = (c % P == 0);
            if (c % P == 0) samp.push_back(sy);
            if (c >= P + 2 && c % P == 2) begin
                k   = (c - 2) / P;
                sk  = samp[k-1];
                sk1 = (k >= 2) ? samp[k-2] : 5'd0;
                sk2 = (k >= 3) ? samp[k-3] : 5'd0;
                for (int i = 0; i < 5; i++) begin
                    if (sk[i] && sk1[i] && !sk2[i]) begin
                        e.pulse[i] = 1'b1;
                        m_level[i] = 1'b1;
                        m_n[i]     = 0;
                    end else if (m_level[i]) begin
                        m_n[i]++;
                        if (MASK[i] && m_n[i] >= D && (m_n[i] - D) % R == 0)
                            e.pulse[i] = 1'b1;
                        if (!sk[i] && !sk1[i]) m_level[i] = 1'b0;
                    end
                end
            end
            e.level = m_level;
        end
        q.push_back(e);
    endtask

    task automatic hold(input logic [4:0] b, input int n);
        repeat (n) step(1'b1, b);
    endtask

    task automatic wait_phase(input int ph);
        while ((c + 1) % P != ph) step(1'b1, 5'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pulse",  int'(pulse),  int'(e.pulse));
            chk("level",  int'(level),  int'(e.level));
            chk("random", int'(random), int'(e.rnd));
            chk("tick",   int'(tick),   int'(e.tick));
        end
        if (pulse[0]) cnt_l++;
        if (pulse[1]) cnt_m++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dur;
        logic [4:0] b;
        for (int i = 0; i < 5; i++) m_n[i] = 0;
        repeat (5) step(1'b0, 5'b11111);
        hold(5'b11111, 3 * P);
        hold(5'b00000, 4 * P);

        cnt_m = 0;
        hold(5'b00010, 100);
        hold(5'b00000, 60);
        chk("m_press_count", cnt_m, 1);

        cnt_l = 0;
        wait_phase(8);
        hold(5'b00001, 16);
        hold(5'b00000, 20);
        wait_phase(4);
        hold(5'b00001, 5);
        hold(5'b00000, 48);
        chk("l_glitch_count", cnt_l, 0);

        cnt_l = 0;
        wait_phase(0);
        hold(5'b01001, 20 * P);
        hold(5'b00000, 4 * P);
        chk("l_norepeat_count", cnt_l, 1);

        hold(5'b00100, 6);
        hold(5'b00000, 10);

        for (int s = 0; s < 40; s++) begin
            b   = 5'($urandom);
            dur = (s % 3 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(16, 90));
            hold(b, dur);
        end
        hold(5'b00000, 4 * P);

        hold(5'b01000, 9 * P);
        repeat (3) step(1'b0, 5'b01000);
        hold(5'b01000, 12 * P);
        hold(5'b00000, 4 * P);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
